// File: rtl/serialtopar_pkg.sv
// Shared serial-link definitions: comma character, lock threshold default and
// the receiver alignment state encoding, common to transmitter and receiver.
package serialtopar_pkg;

  localparam logic [7:0] IDLE_CHAR_DEF = 8'hBC;
  localparam int         BC_LOCK_DEF   = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGNED = 2'd1,
    LOCKED  = 2'd2
  } link_state_t;

endpackage

// File: rtl/serialtopar_if.sv
// Serial-in / byte-out link bundle. The master drives the bit stream, the
// slave (receiver) returns the recovered byte, its valid flag and lock status.
interface serialtopar_if;

  // Handshake: no back-pressure. data_in is taken every clk_32f edge;
  // valid_out qualifies data_out for the current 8-cycle byte slot only.
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );

endinterface

// File: rtl/serialtopar.sv
// Serial-to-parallel receiver: finds byte alignment on repeated comma
// characters, locks after BC_LOCK aligned commas, then emits non-idle bytes.
module serialtopar
  import serialtopar_pkg::*;
#(
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF,
  parameter int         BC_LOCK   = BC_LOCK_DEF
) (
  input  logic          clk_32f,
  input  logic          reset,
  serialtopar_if.slave  link,
  output link_state_t   dbg_state
);

  localparam logic [3:0] LOCK_CNT = 4'(BC_LOCK);

  link_state_t state_q, state_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;

  logic [7:0]  nxt;
  logic        is_idle;
  logic        boundary;
  logic [3:0]  bc_inc;

  always_comb begin
    nxt       = {sreg_q[6:0], link.data_in};
    is_idle   = (nxt == IDLE_CHAR);
    boundary  = (bit_cnt_q == 3'd7);
    bc_inc    = bc_cnt_q + 4'd1;

    state_d   = state_q;
    sreg_d    = nxt;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;

    case (state_q)
      SEARCH: begin
        // Bit-by-bit hunt: the edge that completes a comma defines the boundary.
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
        if (is_idle) begin
          bc_cnt_d = 4'd1;
          if (LOCK_CNT == 4'd1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d  = ALIGNED;
          end
        end
      end
      ALIGNED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_idle) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == LOCK_CNT) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            state_d   = SEARCH;
            bc_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end
      LOCKED: begin
        // Lock is sticky; a comma in a byte slot just blanks valid for that slot.
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_idle) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= SEARCH;
      sreg_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign link.data_out  = data_q;
  assign link.valid_out = valid_q;
  assign link.active    = active_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_serialtopar.sv
// Directed bench for serialtopar: reset, comma lock, payload/idle slots,
// arbitrary bit offset, failed alignment and reset while locked.
module tb_serialtopar;
  import serialtopar_pkg::*;

  logic        clk_32f = 1'b0;
  logic        reset;
  link_state_t dbg_state;

  serialtopar_if sif ();

  serialtopar dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .link      (sif.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk_32f = ~clk_32f;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  obs_d [8];
  logic        obs_v [8];
  logic        obs_a [8];
  link_state_t obs_s [8];

  logic [7:0] cur_d;
  logic       cur_v;
  logic       cur_a;

  // Present one bit ahead of the edge, then sample outputs 1ns after it.
  task automatic drive_bit(input logic b);
    sif.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[7-i]);
      obs_d[i] = sif.data_out;
      obs_v[i] = sif.valid_out;
      obs_a[i] = sif.active;
      obs_s[i] = dbg_state;
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    sif.data_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_32f);
      #1;
      n_cmp++;
      if (sif.data_out !== 8'h00 || sif.valid_out !== 1'b0 || sif.active !== 1'b0 ||
          dbg_state !== SEARCH) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got d=%h v=%b a=%b s=%0d want d=00 v=0 a=0 s=0",
                 c, sif.data_out, sif.valid_out, sif.active, dbg_state);
      end
    end
    reset = 1'b1;
    cur_d = 8'h00; cur_v = 1'b0; cur_a = 1'b0;
  endtask

  task automatic test_lock();
    logic [7:0] b  [4] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC};
    logic       ea [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      send_byte(b[k]);
      for (int i = 0; i < 8; i++) begin
        logic ex_a = (i == 7) ? ea[k] : cur_a;
        n_cmp++;
        if (obs_d[i] !== 8'h00 || obs_v[i] !== 1'b0 || obs_a[i] !== ex_a) begin
          n_bad++;
          $display("FAIL lock byte%0d bit%0d: got d=%h v=%b a=%b want d=00 v=0 a=%b",
                   k, i, obs_d[i], obs_v[i], obs_a[i], ex_a);
        end
      end
      cur_a = ea[k];
    end
  endtask

  task automatic test_data();
    logic [7:0] b  [3] = '{8'h5A, 8'hBC, 8'hC3};
    logic [7:0] ed [3] = '{8'h5A, 8'h5A, 8'hC3};
    logic       ev [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      send_byte(b[k]);
      for (int i = 0; i < 8; i++) begin
        logic [7:0] ex_d = (i == 7) ? ed[k] : cur_d;
        logic       ex_v = (i == 7) ? ev[k] : cur_v;
        n_cmp++;
        if (obs_d[i] !== ex_d || obs_v[i] !== ex_v || obs_a[i] !== 1'b1) begin
          n_bad++;
          $display("FAIL data byte%0d bit%0d: got d=%h v=%b a=%b want d=%h v=%b a=1",
                   k, i, obs_d[i], obs_v[i], obs_a[i], ex_d, ex_v);
        end
      end
      cur_d = ed[k]; cur_v = ev[k];
    end
  endtask

  // One-cycle reset pulse starting 1ns after an edge; outputs checked after it.
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    n_cmp++;
    if (sif.data_out !== 8'h00 || sif.valid_out !== 1'b0 || sif.active !== 1'b0 ||
        dbg_state !== SEARCH) begin
      n_bad++;
      $display("FAIL %s: got d=%h v=%b a=%b s=%0d want d=00 v=0 a=0 s=0",
               tag, sif.data_out, sif.valid_out, sif.active, dbg_state);
    end
    cur_d = 8'h00; cur_v = 1'b0; cur_a = 1'b0;
  endtask

  task automatic test_bit_offset();
    logic [7:0] b  [5] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11};
    logic [7:0] ed [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
    logic       ev [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ea [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pulse_reset("offset_reset");
    for (int p = 0; p < 3; p++) begin
      drive_bit(1'($urandom_range(0, 1)));
      n_cmp++;
      if (sif.active !== 1'b0 || sif.valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL offset prefix%0d: got a=%b v=%b want a=0 v=0",
                 p, sif.active, sif.valid_out);
      end
    end
    for (int k = 0; k < 5; k++) begin
      send_byte(b[k]);
      for (int i = 0; i < 8; i++) begin
        logic [7:0] ex_d = (i == 7) ? ed[k] : cur_d;
        logic       ex_v = (i == 7) ? ev[k] : cur_v;
        logic       ex_a = (i == 7) ? ea[k] : cur_a;
        n_cmp++;
        if (obs_d[i] !== ex_d || obs_v[i] !== ex_v || obs_a[i] !== ex_a) begin
          n_bad++;
          $display("FAIL offset byte%0d bit%0d: got d=%h v=%b a=%b want d=%h v=%b a=%b",
                   k, i, obs_d[i], obs_v[i], obs_a[i], ex_d, ex_v, ex_a);
        end
      end
      cur_d = ed[k]; cur_v = ev[k]; cur_a = ea[k];
    end
  endtask

  task automatic test_no_lock();
    logic [7:0]  b  [7] = '{8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    logic        ea [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    link_state_t es [7] = '{ALIGNED, ALIGNED, SEARCH, ALIGNED, ALIGNED, ALIGNED, LOCKED};
    pulse_reset("nolock_reset");
    for (int k = 0; k < 7; k++) begin
      send_byte(b[k]);
      for (int i = 0; i < 8; i++) begin
        logic ex_a = (i == 7) ? ea[k] : cur_a;
        n_cmp++;
        if (obs_d[i] !== 8'h00 || obs_v[i] !== 1'b0 || obs_a[i] !== ex_a) begin
          n_bad++;
          $display("FAIL nolock byte%0d bit%0d: got d=%h v=%b a=%b want d=00 v=0 a=%b",
                   k, i, obs_d[i], obs_v[i], obs_a[i], ex_a);
        end
      end
      n_cmp++;
      if (obs_s[7] !== es[k]) begin
        n_bad++;
        $display("FAIL nolock_state byte%0d: got s=%0d want s=%0d", k, obs_s[7], es[k]);
      end
      cur_a = ea[k];
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [7:0] b  [5] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h7E};
    logic [7:0] ed [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h7E};
    logic       ev [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ea [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] partial = 8'hA5;
    // Lock first with a known byte so the reset has something to discard.
    cur_d = 8'h00; cur_v = 1'b0; cur_a = 1'b1;
    send_byte(8'h3C);
    n_cmp++;
    if (obs_d[7] !== 8'h3C || obs_v[7] !== 1'b1 || obs_a[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pre: got d=%h v=%b a=%b want d=3c v=1 a=1",
               obs_d[7], obs_v[7], obs_a[7]);
    end
    for (int i = 0; i < 3; i++) drive_bit(partial[7-i]);
    n_cmp++;
    if (sif.data_out !== 8'h3C || sif.valid_out !== 1'b1 || sif.active !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_hold: got d=%h v=%b a=%b want d=3c v=1 a=1",
               sif.data_out, sif.valid_out, sif.active);
    end
    pulse_reset("midreset_clear");
    for (int k = 0; k < 5; k++) begin
      send_byte(b[k]);
      for (int i = 0; i < 8; i++) begin
        logic [7:0] ex_d = (i == 7) ? ed[k] : cur_d;
        logic       ex_v = (i == 7) ? ev[k] : cur_v;
        logic       ex_a = (i == 7) ? ea[k] : cur_a;
        n_cmp++;
        if (obs_d[i] !== ex_d || obs_v[i] !== ex_v || obs_a[i] !== ex_a) begin
          n_bad++;
          $display("FAIL relock byte%0d bit%0d: got d=%h v=%b a=%b want d=%h v=%b a=%b",
                   k, i, obs_d[i], obs_v[i], obs_a[i], ex_d, ex_v, ex_a);
        end
      end
      cur_d = ed[k]; cur_v = ev[k]; cur_a = ea[k];
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_bit_offset();
    test_no_lock();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
